// File: rtl/pkg_opengpu.sv
// Shared FPU definitions: canonical FP32 constants, field view and divider FSM states.
package pkg_opengpu;

  localparam int DATA_WIDTH   = 32;
  localparam int FP_DIV_ITERS = 27;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_ROUND,
    ST_DONE
  } fp_div_state_t;

  // Denormals count as zero everywhere in the FPU.
  function automatic logic fp32_is_zero(input fp32_t v);
    return v.exp == 8'd0;
  endfunction

  function automatic logic fp32_is_inf(input fp32_t v);
    return (v.exp == 8'hFF) && (v.mant == 23'd0);
  endfunction

  function automatic logic fp32_is_nan(input fp32_t v);
    return (v.exp == 8'hFF) && (v.mant != 23'd0);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and pack a normalised FP32 value, with overflow to
// infinity and flush-to-zero on underflow.
module fp_round_pack
  import pkg_opengpu::*;
(
  input  logic              i_sign,
  input  logic signed [9:0] i_exp,
  input  logic [22:0]       i_mant,
  input  logic              i_guard,
  input  logic              i_sticky,
  output logic [31:0]       o_result
);

  logic              w_round_up;
  logic [23:0]       w_mant_sum;
  logic signed [9:0] w_exp;

  assign w_round_up = i_guard & (i_sticky | i_mant[0]);
  assign w_mant_sum = {1'b0, i_mant} + {23'd0, w_round_up};
  // A carry out leaves the fraction bits all zero, which is already the
  // right fraction after the implied shift right.
  assign w_exp      = i_exp + $signed({9'd0, w_mant_sum[23]});

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    o_result = {i_sign, w_exp[7:0], w_mant_sum[22:0]};
    if (w_exp >= 10'sd255) begin
      o_result = FP32_POS_INF | {i_sign, 31'd0};
    end else if (w_exp <= 10'sd0) begin
      o_result = {i_sign, 31'd0};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative FP32 divider: one restoring-division quotient bit per clock,
// then a single round/pack cycle; one operation in flight.
module fp_div_seq
  import pkg_opengpu::*;
#(
  parameter int TAG_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);

  fp_div_state_t r_state, w_state_next;

  fp32_t                w_a, w_b;
  logic                 w_sign_in;
  logic                 w_special;
  logic [31:0]          w_special_result;

  logic                 r_sign;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [23:0]          r_mb;
  logic [24:0]          r_rem;
  logic [26:0]          r_q;
  logic signed [9:0]    r_exp;
  logic [4:0]           r_cnt;
  logic [31:0]          r_result;
  logic [TAG_WIDTH-1:0] r_out_tag;

  logic                 w_last;
  logic                 w_ge;
  logic [24:0]          w_rem_sub;
  logic [22:0]          w_norm_mant;
  logic                 w_norm_guard;
  logic                 w_norm_sticky;
  logic signed [9:0]    w_norm_exp;
  logic [31:0]          w_packed;

  assign w_a       = in_a;
  assign w_b       = in_b;
  assign w_sign_in = w_a.sign ^ w_b.sign;

  always_comb begin
    w_special        = 1'b0;
    w_special_result = {w_sign_in, 31'd0};
    if (fp32_is_nan(w_a) || fp32_is_nan(w_b)) begin
      w_special        = 1'b1;
      w_special_result = FP32_QNAN;
    end else if ((fp32_is_inf(w_a) && fp32_is_inf(w_b)) ||
                 (fp32_is_zero(w_a) && fp32_is_zero(w_b))) begin
      w_special        = 1'b1;
      w_special_result = FP32_QNAN;
    end else if (fp32_is_inf(w_a) || fp32_is_zero(w_b)) begin
      w_special        = 1'b1;
      w_special_result = FP32_POS_INF | {w_sign_in, 31'd0};
    end else if (fp32_is_zero(w_a) || fp32_is_inf(w_b)) begin
      w_special        = 1'b1;
      w_special_result = {w_sign_in, 31'd0};
    end
  end

  assign w_last    = (r_cnt == 5'(FP_DIV_ITERS - 1));
  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (in_valid)  w_state_next = w_special ? ST_DONE : ST_DIVIDE;
      ST_DIVIDE: if (w_last)    w_state_next = ST_ROUND;
      ST_ROUND:                 w_state_next = ST_DONE;
      ST_DONE:   if (out_ready) w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // The quotient's integer bit lands in q[26] when ma >= mb; otherwise the
  // leading one is one place lower and the exponent drops by one.
  always_comb begin
    if (r_q[26]) begin
      w_norm_mant   = r_q[25:3];
      w_norm_guard  = r_q[2];
      w_norm_sticky = (|r_q[1:0]) | (|r_rem);
      w_norm_exp    = r_exp;
    end else begin
      w_norm_mant   = r_q[24:2];
      w_norm_guard  = r_q[1];
      w_norm_sticky = r_q[0] | (|r_rem);
      w_norm_exp    = r_exp - 10'sd1;
    end
  end

  fp_round_pack u_round_pack (
    .i_sign   (r_sign),
    .i_exp    (w_norm_exp),
    .i_mant   (w_norm_mant),
    .i_guard  (w_norm_guard),
    .i_sticky (w_norm_sticky),
    .o_result (w_packed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign    <= 1'b0;
      r_tag     <= '0;
      r_mb      <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_exp     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_out_tag <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign_in;
            r_tag  <= in_tag;
            r_mb   <= {1'b1, w_b.mant};
            r_rem  <= {2'b01, w_a.mant};
            r_exp  <= $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp}) + 10'sd127;
            r_cnt  <= '0;
            r_q    <= '0;
            if (w_special) begin
              r_result  <= w_special_result;
              r_out_tag <= in_tag;
            end
          end
        end
        ST_DIVIDE: begin
          r_rem <= w_rem_sub << 1;
          r_q   <= {r_q[25:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        ST_ROUND: begin
          r_result  <= w_packed;
          r_out_tag <= r_tag;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;
  assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases, backpressure, reset
// mid-operation and randomized operands against an exact-division model.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [7:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_div_seq #(.TAG_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, got, exp);
    end
  endtask

  // Exact quotient by wide integer division, then IEEE rounding rules.
  function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output bit special);
    int                ea = int'(a[30:23]);
    int                eb = int'(b[30:23]);
    logic              s  = a[31] ^ b[31];
    bit a_nan  = (ea == 255) && (a[22:0] != 0);
    bit b_nan  = (eb == 255) && (b[22:0] != 0);
    bit a_inf  = (ea == 255) && (a[22:0] == 0);
    bit b_inf  = (eb == 255) && (b[22:0] == 0);
    bit a_zero = (ea == 0);
    bit b_zero = (eb == 0);
    longint unsigned num, den, q, r, sig;
    int  e, sh;
    bit  guard, sticky;
    special = 1'b1;
    if (a_nan || b_nan)                          begin res = 32'h7FC00000; return; end
    if ((a_inf && b_inf) || (a_zero && b_zero))  begin res = 32'h7FC00000; return; end
    if (a_inf || b_zero)                         begin res = {s, 8'hFF, 23'd0}; return; end
    if (a_zero || b_inf)                         begin res = {s, 31'd0}; return; end
    special = 1'b0;
    num = {40'd1, a[22:0]} << 38;
    den = {40'd1, b[22:0]};
    q = num / den;
    r = num % den;
    e = ea - eb + 127;
    if (q >= (64'd1 << 38)) sh = 15;
    else begin
      sh = 14;
      e  = e - 1;
    end
    sig    = q >> sh;
    guard  = ((q >> (sh - 1)) & 64'd1) != 0;
    sticky = ((q & ((64'd1 << (sh - 1)) - 64'd1)) != 0) || (r != 0);
    if (guard && (sticky || sig[0])) sig = sig + 1;
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 255)    res = {s, 8'hFF, 23'd0};
    else if (e <= 0) res = {s, 31'd0};
    else             res = {s, 8'(e), sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    int          k = $urandom_range(0, 11);
    logic        s = 1'($urandom);
    logic [22:0] m = 23'($urandom);
    case (k)
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, m | 23'd1};
      3:       return {s, 8'd0, m};
      4:       return {s, 8'($urandom_range(1, 254)), m};
      default: return {s, 8'($urandom_range(100, 154)), m};
    endcase
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
    @(negedge clk);
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_tag = 8'($urandom);
  endtask

  // Latency counts the accept cycle's successor as 1.
  task automatic wait_valid(output int lat, output bit ready_seen);
    lat = 1;
    ready_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready === 1'b1) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] tag, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit rs;
    issue(a, b, tag);
    wait_valid(lat, rs);
    check({name, " result"}, out_result, exp_res);
    check({name, " tag"}, 32'(out_tag), 32'(tag));
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " in_ready low while busy"}, 32'(rs), 32'd0);
    @(posedge clk);
    #1;
    check({name, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rexp, held_res;
    logic [7:0]  held_tag;
    bit          sp;
    int          lat;
    bit          rs;

    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset out_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("6/2",        32'h40C00000, 32'h40000000, 8'h5A, 32'h40400000, 29);
    run_op("1/3",        32'h3F800000, 32'h40400000, 8'h01, 32'h3EAAAAAB, 29);
    run_op("-1/3",       32'hBF800000, 32'h40400000, 8'h02, 32'hBEAAAAAB, 29);
    run_op("1.5/1",      32'h3FC00000, 32'h3F800000, 8'h03, 32'h3FC00000, 29);
    run_op("1/+0",       32'h3F800000, 32'h00000000, 8'h10, 32'h7F800000, 1);
    run_op("-1/+0",      32'hBF800000, 32'h00000000, 8'h11, 32'hFF800000, 1);
    run_op("0/0",        32'h00000000, 32'h00000000, 8'h12, 32'h7FC00000, 1);
    run_op("inf/inf",    32'h7F800000, 32'h7F800000, 8'h13, 32'h7FC00000, 1);
    run_op("2/inf",      32'h40000000, 32'h7F800000, 8'h14, 32'h00000000, 1);
    run_op("nan/1",      32'h7FC00001, 32'h3F800000, 8'h15, 32'h7FC00000, 1);
    run_op("denorm/1",   32'h00000001, 32'h3F800000, 8'h16, 32'h00000000, 1);
    run_op("1/denorm",   32'h3F800000, 32'h00000001, 8'h17, 32'h7F800000, 1);
    run_op("overflow",   32'h7F000000, 32'h3E800000, 8'h20, 32'h7F800000, 29);
    run_op("underflow",  32'h00800000, 32'h40000000, 8'h21, 32'h00000000, 29);
    run_op("-underflow", 32'h80800000, 32'h40000000, 8'h22, 32'h80000000, 29);

    // Backpressure: result held, second request refused until DONE is left.
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, 8'h33);
    wait_valid(lat, rs);
    check("bp first latency", 32'(lat), 32'd29);
    held_res = out_result;
    held_tag = out_tag;
    check("bp first result", held_res, 32'h40400000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_a = 32'h3F800000; in_b = 32'h40400000; in_tag = 8'h44; in_valid = 1'b1;
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp result stable", out_result, held_res);
      check("bp tag stable", 32'(out_tag), 32'h33);
      check("bp in_ready low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp back to idle", 32'(in_ready), 32'd1);
    check("bp out_valid dropped", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp second accepted", 32'(busy), 32'd1);
    wait_valid(lat, rs);
    check("bp second result", out_result, 32'h3EAAAAAB);
    check("bp second tag", 32'(out_tag), 32'h44);
    check("bp second latency", 32'(lat), 32'd29);
    @(posedge clk);
    #1;

    // Asynchronous reset partway through DIVIDE.
    issue(32'h40C00000, 32'h40000000, 8'h77);
    repeat (10) @(posedge clk);
    #2;
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    check("mid reset out_result", out_result, 32'd0);
    check("mid reset out_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-reset 6/2", 32'h40C00000, 32'h40000000, 8'h5A, 32'h40400000, 29);

    for (int i = 0; i < 40; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      if ((i % 2) == 0 && ra[30:23] > 8'd4 && ra[30:23] < 8'd250)
        rb = {rb[31], ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3, rb[22:0]};
      model_div(ra, rb, rexp, sp);
      run_op($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb, 8'($urandom), rexp, sp ? 1 : 29);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
